// File: rtl/lfsr_gen_if.sv
// Control and status bundle for lfsr_gen.
// The master drives step/load requests. The slave (the generator) returns state and status.
interface lfsr_gen_if #(
   parameter int unsigned WIDTH = 6
);
   logic             en;
   logic             load;
   logic [WIDTH-1:0] seed_in;
   logic [WIDTH-1:0] q;
   logic             wrap;
   logic [WIDTH-1:0] period;
   logic             lockup;

   modport master (
      output en,
      output load,
      output seed_in,
      input  q,
      input  wrap,
      input  period,
      input  lockup
   );

   modport slave (
      input  en,
      input  load,
      input  seed_in,
      output q,
      output wrap,
      output period,
      output lockup
   );
endinterface

// File: rtl/lfsr_gen.sv
// Parametrised Galois LFSR with runtime seed load, step enable, period measurement
// and recovery from the all-zero lock-up state.
module lfsr_gen #(
   parameter int unsigned      WIDTH = 6,
   parameter logic [WIDTH-1:0] TAPS  = 6'b110100,
   parameter logic [WIDTH-1:0] SEED  = {WIDTH{1'b1}}
) (
   input logic        clk,
   input logic        rst_b,
   lfsr_gen_if.slave  bus
);

   // Reject parameter sets that cannot produce a useful sequence.
   if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_gen: WIDTH must be in 3..32");
   end
   if (SEED == '0) begin : g_bad_seed
      $error("lfsr_gen: SEED must be non-zero");
   end

   // Stage 0 always takes the feedback bit, whatever TAPS[0] says.
   localparam logic [WIDTH-1:0] FB_MASK = {TAPS[WIDTH-1:1], 1'b1};

   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] start_q, start_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             wrap_q, wrap_d;
   logic             lockup_q, lockup_d;
   logic [WIDTH-1:0] step_val;

   // One Galois step: shift up and fold the old MSB into the tapped stages.
   always_comb begin
      step_val = {q_q[WIDTH-2:0], 1'b0} ^ ({WIDTH{q_q[WIDTH-1]}} & FB_MASK);
   end

   // Next-state selection with load > step > hold priority.
   always_comb begin
      q_d      = q_q;
      start_d  = start_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      wrap_d   = 1'b0;
      lockup_d = 1'b0;
      if (bus.load) begin
         q_d      = bus.seed_in;
         start_d  = bus.seed_in;
         cnt_d    = '0;
         period_d = '0;
      end else if (bus.en) begin
         if (q_q == '0) begin
            // Zero is a fixed point of the step map; restart from SEED, keep old period.
            q_d      = SEED;
            start_d  = SEED;
            cnt_d    = '0;
            lockup_d = 1'b1;
         end else begin
            q_d = step_val;
            if (step_val == start_q) begin
               // Orbit length never exceeds 2^WIDTH-1, so cnt+1 always fits.
               wrap_d   = 1'b1;
               period_d = cnt_q + 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         q_q      <= SEED;
         start_q  <= SEED;
         cnt_q    <= '0;
         period_q <= '0;
         wrap_q   <= 1'b0;
         lockup_q <= 1'b0;
      end else begin
         q_q      <= q_d;
         start_q  <= start_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         wrap_q   <= wrap_d;
         lockup_q <= lockup_d;
      end
   end

   assign bus.q      = q_q;
   assign bus.wrap   = wrap_q;
   assign bus.period = period_q;
   assign bus.lockup = lockup_q;

endmodule
